// File: rtl/psum_drain.sv
// psum_drain: column drain for the systolic array.
// Resolves the carry-save psum pair leaving the last PE row and accumulates
// TILES resolved sums into one signed result. Results are queued in a small
// FIFO that is read through a valid/ready stream.
module psum_drain #(
    parameter int SIZE  = 4,
    parameter int BUS   = $clog2(SIZE) + 16,
    parameter int TILES = 2,
    parameter int DEPTH = 4,
    parameter int ACCW  = BUS + $clog2(TILES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BUS-1:0]             psum0,
    input  logic [BUS-1:0]             psum1,
    input  logic                       abort,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACCW-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (TILES > 1) ? $clog2(TILES) : 1;

    localparam logic [TW-1:0] LAST_TILE = TW'(TILES - 1);
    localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(DEPTH);

    // Sign-extend a resolved BUS-bit sum to the accumulator width.
    function automatic logic [ACCW-1:0] sext_sum(input logic [BUS-1:0] s);
        return ACCW'($signed(s));
    endfunction

    // Resolve stage
    logic             s1_valid_r;
    logic [BUS-1:0]   s1_sum_r;

    // Accumulate stage
    logic [ACCW-1:0]  acc_r;
    logic [TW-1:0]    tile_cnt_r;

    // Result FIFO
    logic [ACCW-1:0]  fifo_mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             out_valid_r;

    logic             s1_final_s;
    logic [CW:0]      occ_s;
    logic             ready_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic [ACCW-1:0]  acc_next_s;
    logic [CW-1:0]    count_next_s;

    // Handshake decode and next-state arithmetic. in_ready depends only on
    // registered state: the FIFO occupancy plus a result already committed
    // in S1, so a write into the FIFO can never find it full.
    always_comb begin
        s1_final_s = s1_valid_r && (tile_cnt_r == LAST_TILE);
        occ_s      = {1'b0, count_r} + {{CW{1'b0}}, s1_final_s};
        ready_s    = (occ_s < DEPTH_LIM);
        accept_s   = in_valid && ready_s && !abort;
        push_s     = s1_final_s && !abort;
        pop_s      = out_valid_r && out_ready;
        acc_next_s = acc_r + sext_sum(s1_sum_r);
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    assign in_ready  = ready_s;
    assign out_valid = out_valid_r;
    assign count     = count_r;
    assign out_data  = fifo_mem_r[rd_ptr_r];

    // S1: register the carry-propagate sum of an accepted pair; carry-out dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_sum_r   <= {BUS{1'b0}};
        end else if (abort) begin
            s1_valid_r <= 1'b0;
            s1_sum_r   <= s1_sum_r;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_sum_r   <= psum0 + psum1;
        end else begin
            s1_valid_r <= 1'b0;
            s1_sum_r   <= s1_sum_r;
        end
    end

    // Accumulator and tile counter; the last tile of a result is written out and the accumulator restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= {ACCW{1'b0}};
            tile_cnt_r <= {TW{1'b0}};
        end else if (abort) begin
            acc_r      <= {ACCW{1'b0}};
            tile_cnt_r <= {TW{1'b0}};
        end else if (s1_valid_r) begin
            if (s1_final_s) begin
                acc_r      <= {ACCW{1'b0}};
                tile_cnt_r <= {TW{1'b0}};
            end else begin
                acc_r      <= acc_next_s;
                tile_cnt_r <= tile_cnt_r + TW'(1);
            end
        end else begin
            acc_r      <= acc_r;
            tile_cnt_r <= tile_cnt_r;
        end
    end

    // FIFO storage: write the completed result at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= {ACCW{1'b0}};
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= acc_next_s;
        end else begin
            fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy and head-valid flag; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r     <= count_next_s;
            out_valid_r <= (count_next_s != {CW{1'b0}});
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: a TILES=1 instance for the resolve/latency
// table and a TILES=2 instance for accumulation, backpressure, abort and reset.
module tb_psum_drain;

    logic        clk;
    logic        rst_n;

    // TILES=1 instance
    logic        in_valid_1, in_ready_1, abort_1, out_valid_1, out_ready_1;
    logic [17:0] psum0_1, psum1_1;
    logic [17:0] out_data_1;
    logic [2:0]  count_1;

    // TILES=2 instance
    logic        in_valid, in_ready, abort, out_valid, out_ready;
    logic [17:0] psum0, psum1;
    logic [18:0] out_data;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    psum_drain #(.TILES(1)) u_t1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
        .psum0(psum0_1), .psum1(psum1_1), .abort(abort_1), .out_valid(out_valid_1),
        .out_ready(out_ready_1), .out_data(out_data_1), .count(count_1)
    );

    psum_drain #(.TILES(2)) u_t2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .psum0(psum0), .psum1(psum1), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] p0;
        logic [17:0] p1;
        int          exp;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Present one pair to the TILES=2 instance for one edge (caller is at a negedge).
    task automatic put2(input logic [17:0] a, input logic [17:0] b);
        in_valid = 1'b1;
        psum0    = a;
        psum1    = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Check the FIFO head of the TILES=2 instance and pop it.
    task automatic pop2(input string name, input int exp);
        logic [18:0] e19;
        e19 = 19'(exp);
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_data"}, {13'd0, out_data}, {13'd0, e19});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Wait (bounded) for the TILES=2 head to become valid.
    task automatic wait_valid2(input string name, input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        logic [17:0] e18;
        logic [18:0] e19;
        logic [18:0] got [$];
        int          k;
        logic        rdy;
        logic        saw_not_ready;

        rst_n = 1'b0;
        in_valid_1 = 1'b0; abort_1 = 1'b0; out_ready_1 = 1'b0; psum0_1 = 18'd0; psum1_1 = 18'd0;
        in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; psum0 = 18'd0; psum1 = 18'd0;

        tbl[0] = '{18'h00010, 18'h00005, 21};
        tbl[1] = '{18'h3FFFF, 18'h00002, 1};
        tbl[2] = '{18'h20000, 18'h00000, -131072};
        tbl[3] = '{18'h3FFFF, 18'h3FFFF, -2};
        tbl[4] = '{18'h12345, 18'h00001, 74566};
        tbl[5] = '{18'h1FFFF, 18'h00000, 131071};

        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {13'd0, out_data}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_count_t1", {29'd0, count_1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // TILES=1 table: resolve, wrap, sign extension, 2-edge latency
        for (int i = 0; i < 6; i++) begin
            e18 = 18'(tbl[i].exp);
            in_valid_1 = 1'b1;
            psum0_1 = tbl[i].p0;
            psum1_1 = tbl[i].p1;
            @(negedge clk);
            in_valid_1 = 1'b0;
            check($sformatf("t1_lat1_%0d", i), {31'd0, out_valid_1}, 32'd0);
            @(negedge clk);
            check($sformatf("t1_valid_%0d", i), {31'd0, out_valid_1}, 32'd1);
            check($sformatf("t1_data_%0d", i), {14'd0, out_data_1}, {14'd0, e18});
            out_ready_1 = 1'b1;
            @(negedge clk);
            out_ready_1 = 1'b0;
            check($sformatf("t1_empty_%0d", i), {29'd0, count_1}, 32'd0);
        end

        // TILES=2: back-to-back accumulate
        put2(18'd100, 18'(-50));
        put2(18'd7, 18'd3);
        check("acc_lat", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("acc_count", {29'd0, count}, 32'd1);
        check("acc_data", {13'd0, out_data}, 32'd60);
        put2(18'd1, 18'd1);
        repeat (3) @(negedge clk);
        check("lone_pair_count", {29'd0, count}, 32'd1);
        pop2("acc_pop", 60);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // Simultaneous push and pop with one entry queued
        put2(18'd1, 18'd0);
        put2(18'd2, 18'd0);
        @(negedge clk);
        check("pp_pre_count", {29'd0, count}, 32'd1);
        put2(18'd4, 18'd0);
        put2(18'd5, 18'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("pp_count", {29'd0, count}, 32'd1);
        pop2("pp_pop", 9);

        // Backpressure: fill with out_ready=0, then drain while streaming
        k = 0;
        saw_not_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (k < 10) begin
                in_valid = 1'b1;
                psum0 = 18'(3 * (k + 1));
                psum1 = 18'(k + 1);
            end else begin
                in_valid = 1'b0;
            end
            rdy = in_ready;
            if (!rdy) saw_not_ready = 1'b1;
            @(negedge clk);
            if (in_valid && rdy) k++;
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(k), 32'd8);
        check("bp_count_full", {29'd0, count}, 32'd4);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_saw_not_ready", {31'd0, saw_not_ready}, 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 60 && got.size() < 5; c++) begin
            if (k < 10) begin
                in_valid = 1'b1;
                psum0 = 18'(3 * (k + 1));
                psum1 = 18'(k + 1);
            end else begin
                in_valid = 1'b0;
            end
            rdy = in_ready;
            if (out_valid) got.push_back(out_data);
            @(negedge clk);
            if (in_valid && rdy) k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("bp_results", 32'(got.size()), 32'd5);
        for (int j = 0; j < got.size(); j++) begin
            e19 = 19'(16 * j + 12);
            check($sformatf("bp_order_%0d", j), {13'd0, got[j]}, {13'd0, e19});
        end
        @(negedge clk);
        check("bp_drained", {29'd0, count}, 32'd0);

        // abort mid-tile
        put2(18'd5, 18'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        put2(18'd1, 18'd1);
        put2(18'd2, 18'd2);
        wait_valid2("abort_wait", 5);
        check("abort_count", {29'd0, count}, 32'd1);
        check("abort_data", {13'd0, out_data}, 32'd6);
        // abort with a pending entry, dropping a pair accepted on the same edge
        in_valid = 1'b1; psum0 = 18'd9; psum1 = 18'd9; abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        check("abort_keep_count", {29'd0, count}, 32'd1);
        check("abort_keep_data", {13'd0, out_data}, 32'd6);
        put2(18'd1, 18'd1);
        put2(18'd2, 18'd2);
        @(negedge clk);
        check("abort2_count", {29'd0, count}, 32'd2);
        pop2("abort_pop_a", 6);
        pop2("abort_pop_b", 6);

        // Asynchronous reset mid-operation
        for (int j = 0; j < 7; j++) begin
            put2(18'(j + 1), 18'd0);
        end
        repeat (2) @(negedge clk);
        check("pre_rst_count", {29'd0, count}, 32'd3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", {29'd0, count}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_out_data", {13'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        put2(18'd10, 18'd0);
        put2(18'd20, 18'd0);
        wait_valid2("post_rst_wait", 5);
        check("post_rst_count", {29'd0, count}, 32'd1);
        pop2("post_rst_pop", 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
